// File: rtl/mem_stream_mux_if.sv
// Output stream bundle of mem_stream_mux.
// The master drives the word, valid and last flags; the slave drives ready.
interface mem_stream_mux_if #(
    parameter int W = 48
) ();
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_stream_mux.sv
// Per-BX readout mux: header, tagged port words in port order, trailer.
// A single output register is reloaded only when empty or being accepted.
module mem_stream_mux #(
    parameter int NPORTS    = 12,
    parameter int DWIDTH    = 44,
    parameter int TAG_W     = 4,
    parameter int BX_W      = 3,
    parameter int MAX_WORDS = 108
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BX_W-1:0]          bx_in,
    input  logic                     bx_start,
    input  logic [NPORTS-1:0]        port_valid,
    input  logic [NPORTS*DWIDTH-1:0] port_data,
    output logic [NPORTS-1:0]        port_rd,
    mem_stream_mux_if.master         strm,
    output logic                     busy,
    output logic                     err_overrun
);
    localparam int OW    = TAG_W + DWIDTH;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int CUR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [TAG_W-1:0] TAG_HDR  = {TAG_W{1'b1}};
    localparam logic [TAG_W-1:0] TAG_TRL  = {{(TAG_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WORDS);
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NPORTS - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

    state_t            state;
    logic [BX_W-1:0]   bx_q;
    logic [BX_W-1:0]   pend_bx;
    logic              pending;
    logic              trunc;
    logic [CNT_W-1:0]  count;
    logic [CUR_W-1:0]  cur;
    logic              free;
    logic              take;
    logic              consume;
    logic              late_start;
    logic [DWIDTH-1:0] cur_word;

    function automatic logic [OW-1:0] hdr_word(input logic [BX_W-1:0] bx);
        logic [DWIDTH-1:0] p;
        p = '0;
        p[DWIDTH-1 -: BX_W] = bx;
        return {TAG_HDR, p};
    endfunction

    function automatic logic [OW-1:0] trl_word(
        input logic [BX_W-1:0]  bx,
        input logic [CNT_W-1:0] cnt,
        input logic             tr
    );
        logic [DWIDTH-1:0] p;
        p = '0;
        p[CNT_W-1:0] = cnt;
        p[CNT_W] = tr;
        p[CNT_W+1 +: BX_W] = bx;
        return {TAG_TRL, p};
    endfunction

    assign free       = !strm.out_valid || strm.out_ready;
    assign cur_word   = port_data[int'(cur)*DWIDTH +: DWIDTH];
    assign take       = (state == DATA) && free && !pending &&
                        (count != CNT_MAX) && port_valid[cur];
    assign consume    = (state == TRL) && free && pending;
    assign late_start = (state == TRL) && free && !pending;
    assign busy       = (state != IDLE);

    // Pop strobe for the port whose word is loaded this cycle.
    always_comb begin
        port_rd = '0;
        if (take) port_rd[cur] = 1'b1;
    end

    // Queued BX: a start while busy waits here; a second one overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            pend_bx     <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;
            if (consume) begin
                pending <= bx_start;
                if (bx_start) pend_bx <= bx_in;
            end else if (bx_start && busy && !late_start) begin
                pending     <= 1'b1;
                pend_bx     <= bx_in;
                err_overrun <= pending;
            end
        end
    end

    // Frame sequencer driving the registered output word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bx_q           <= '0;
            cur            <= '0;
            count          <= '0;
            trunc          <= 1'b0;
            strm.out_data  <= '0;
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
        end else begin
            if (free) begin
                strm.out_valid <= 1'b0;
                strm.out_last  <= 1'b0;
            end
            unique case (state)
                IDLE: if (bx_start) begin
                    bx_q <= bx_in;
                    if (free) begin
                        strm.out_data  <= hdr_word(bx_in);
                        strm.out_valid <= 1'b1;
                        cur            <= '0;
                        count          <= '0;
                        state          <= DATA;
                    end else begin
                        state <= HDR;
                    end
                end
                HDR: if (free) begin
                    strm.out_data  <= hdr_word(bx_q);
                    strm.out_valid <= 1'b1;
                    cur            <= '0;
                    count          <= '0;
                    state          <= DATA;
                end
                DATA: if (free) begin
                    if (pending || count == CNT_MAX) begin
                        trunc <= 1'b1;
                        state <= TRL;
                    end else if (port_valid[cur]) begin
                        strm.out_data  <= {TAG_W'(cur) + TAG_W'(1), cur_word};
                        strm.out_valid <= 1'b1;
                        count          <= count + 1'b1;
                    end else if (cur == CUR_LAST) begin
                        trunc <= 1'b0;
                        state <= TRL;
                    end else begin
                        cur <= cur + 1'b1;
                    end
                end
                TRL: if (free) begin
                    strm.out_data  <= trl_word(bx_q, count, trunc);
                    strm.out_valid <= 1'b1;
                    strm.out_last  <= 1'b1;
                    if (pending) begin
                        bx_q  <= pend_bx;
                        state <= HDR;
                    end else if (bx_start) begin
                        bx_q  <= bx_in;
                        state <= HDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_stream_mux.md
# mem_stream_mux

Parametrised per-BX readout multiplexer. It drains up to NPORTS memory ports in ascending port order and frames each BX as a header word, then tagged data words, then a trailer word. The trailer carries the word count and a truncation flag. Output uses a valid/ready handshake so the downstream link can stall. It sits between the memory read ports and the serial link / priority-encoder readout path.

## Interface
- NPORTS, 12: number of input ports (1..(2^TAG_W)-3).
- DWIDTH, 44: payload width per port word.
- TAG_W, 4: tag field width; out word = TAG_W+DWIDTH bits.
- BX_W, 3: BX number width.
- MAX_WORDS, 108: max data words per BX before truncation; CNT_W = clog2(MAX_WORDS+1); requires DWIDTH >= CNT_W+1+BX_W.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- bx_in  in  BX_W  BX number, sampled when bx_start=1.
- bx_start  in  1  one-cycle pulse, new BX event begins.
- port_valid  in  NPORTS  port i has a word on port_data.
- port_data  in  NPORTS*DWIDTH  port i word at [i*DWIDTH +: DWIDTH].
- port_rd  out  NPORTS  one-hot pop strobe; word accepted this cycle.
- out_data  out  TAG_W+DWIDTH  registered output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid&out_ready.
- out_last  out  1  high with the trailer word.
- busy  out  1  FSM not in IDLE.
- err_overrun  out  1  one-cycle pulse: bx_start while a pending BX already queued.

## Operation
- Tags: TAG_HDR = all ones; TAG_TRL = all ones minus 1; data from port i uses tag i+1; tag 0 is never emitted.
- Header word: {TAG_HDR, bx, zeros}, where bx occupies payload MSBs [DWIDTH-1 -: BX_W].
- Trailer word payload, LSB first: count[CNT_W-1:0], trunc at bit CNT_W, bx at [CNT_W+1 +: BX_W], rest zero.
- Output slot free = !out_valid | out_ready. The slot loads only when free; otherwise out_data holds.
- FSM states:
  - IDLE: on bx_start, latch bx and go to HDR.
  - HDR: when slot free, load header, set cur=0, count=0, go to DATA.
  - DATA, slot free and pending=1: go to TRL with trunc=1.
  - DATA, slot free and count==MAX_WORDS: go to TRL with trunc=1.
  - DATA, slot free and port_valid[cur]: assert port_rd[cur] combinationally, load {cur+1, port_data[cur]}, count++.
  - DATA, slot free and port cur empty: if cur==NPORTS-1 go to TRL with trunc=0, else cur++ (one cycle per empty port).
  - DATA, slot not free: no port_rd, no state change.
  - TRL: when slot free, load trailer, assert out_last. If pending: go to HDR with the pending bx and clear pending. Else go to IDLE.
- Data left in ports after truncation stays there and is read in the next BX.
- bx_start while busy: set pending and latch bx_in into the pending register.
- bx_start while pending already set: overwrite the pending bx and pulse err_overrun.
- bx_start in the same cycle the FSM enters IDLE from TRL is accepted as a normal start.
- port_rd is never asserted outside DATA, never for more than one port, and never while the slot is blocked.

## Timing
- Reset (async assert, sync release) values: out_data=0, out_valid=0, out_last=0, port_rd=0, busy=0, err_overrun=0, state=IDLE, pending=0, count=0, cur=0.
- bx_start at cycle t in IDLE: header has out_valid=1 at t+1 (HDR loads at t, registered).
- Port word popped (port_rd high) at cycle c appears on out_data at c+1.
- Throughput with out_ready held high: 1 word/cycle, plus 1 cycle per empty port scanned.
- out_valid stays high and out_data stable until accepted. out_last is only high together with out_valid.
- Reset mid-event: everything returns to reset values immediately. Partial frames are discarded, with no trailer.

## Test plan
- NPORTS=12, out_ready=1; bx_start bx_in=5; port 0 holds 2 words, port 3 holds 1, others empty → header {F,5}, two tag-1 words, one tag-4 word, trailer count=3 trunc=0 bx=5 out_last=1; busy falls the cycle after the trailer.
- Same stimulus with out_ready toggling 1/0 every cycle → identical word sequence; no port_rd while the slot is blocked; out_data stable while out_valid&!out_ready.
- MAX_WORDS=4, port 2 holds 6 words → 4 tag-3 words, trailer count=4 trunc=1; port 2 keeps 2 words; next bx_start drains them first.
- bx_start bx=1, then bx_start bx=2 mid-drain → current frame ends with trailer trunc=1 bx=1, then header bx=2 follows with no idle cycle.
- Third bx_start (bx=3) while bx=2 is already pending → err_overrun pulses 1 cycle; next header carries bx=3.
- Assert reset during the DATA state → all outputs 0 at once; after release, bx_start produces a clean header.
